// File: rtl/psum_tile_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared types for the partial-sum tile accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } acc_state_e;

    typedef enum logic {
        RAW     = 1'b0,
        REQUANT = 1'b1
    } acc_mode_e;

    typedef logic signed [LANE_W-1:0] lane_t;

endpackage
`default_nettype wire

// File: rtl/psum_tile_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : psum_tile_accumulator_if
// Description : Config, input-row and output-row bundle of the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface psum_tile_accumulator_if #(
    parameter int N_SIZE     = 32,
    parameter int ACC_W      = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int KT_W       = 8
);
    logic                       cfg_valid;
    logic                       cfg_ready;
    logic [ADDR_WIDTH:0]        cfg_rows;
    logic [KT_W-1:0]            cfg_k_tiles;
    logic                       cfg_mode;
    logic [4:0]                 cfg_shift;
    logic                       in_valid;
    logic                       in_ready;
    logic [N_SIZE*ACC_W-1:0]    in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [N_SIZE*ACC_W-1:0]    out_data;
    logic                       out_last;
    logic                       busy;
    logic                       done;
    logic                       err_cfg;

    modport slave (
        input  cfg_valid, cfg_rows, cfg_k_tiles, cfg_mode, cfg_shift,
        input  in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_data, out_last,
        output busy, done, err_cfg
    );

    modport master (
        output cfg_valid, cfg_rows, cfg_k_tiles, cfg_mode, cfg_shift,
        output in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data, out_last,
        input  busy, done, err_cfg
    );
endinterface
`default_nettype wire

// File: rtl/psum_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : psum_out_fifo
// Description : Two-entry first-word-fall-through FIFO for finished rows.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_out_fifo #(
    parameter int WIDTH = 1025
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] pop_data,
    output logic                  valid,
    output logic      [1:0]       count
);
    logic [WIDTH-1:0] r_buf [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is accepted when the head leaves the same cycle.
    assign w_do_pop  = pop && (r_count != 2'd0);
    assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_buf[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_buf[r_rd_ptr];
    assign valid    = (r_count != 2'd0);
    assign count    = r_count;
endmodule
`default_nettype wire

// File: rtl/psum_tile_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : psum_tile_accumulator
// Description : Lane-wise K-tile partial-sum accumulator with raw/requant
//               row streaming behind a two-entry output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_tile_accumulator
    import systolic_pkg::*;
#(
    parameter int N_SIZE     = 32,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8,
    parameter int MAX_ROWS   = 512,
    parameter int ADDR_WIDTH = $clog2(MAX_ROWS),
    parameter int KT_W       = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    psum_tile_accumulator_if.slave bus
);
    localparam int                      c_DATA_W   = N_SIZE * ACC_W;
    localparam logic [ADDR_WIDTH:0]     c_MAX_ROWS = (ADDR_WIDTH+1)'(MAX_ROWS);
    localparam logic signed [ACC_W:0]   c_ONE      = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0]   c_QMAX     = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0]   c_QMIN     = ~c_QMAX;

    acc_state_e                 r_state;
    logic                       r_cfg_ready;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_err_cfg;
    logic [ADDR_WIDTH:0]        r_rows;
    logic [KT_W-1:0]            r_k_tiles;
    acc_mode_e                  r_mode;
    logic [4:0]                 r_shift;
    logic [ADDR_WIDTH-1:0]      r_row_cnt;
    logic [KT_W-1:0]            r_kt_cnt;

    logic                       r_s1_valid;
    logic                       r_s1_first;
    logic                       r_s1_final;
    logic                       r_s1_last;
    logic [ADDR_WIDTH-1:0]      r_s1_row;
    logic [c_DATA_W-1:0]        r_s1_data;

    logic [c_DATA_W-1:0]        r_mem [MAX_ROWS];

    logic                       w_row_last;
    logic                       w_final_pass;
    logic                       w_in_fire;
    logic                       w_cfg_fire;
    logic                       w_cfg_bad;
    logic                       w_inflight;
    logic                       w_room;
    logic                       w_in_ready;
    logic                       w_out_fire;
    logic [c_DATA_W-1:0]        w_rd_row;
    wire  [c_DATA_W-1:0]        w_sum_row;
    wire  [c_DATA_W-1:0]        w_out_row;
    logic [c_DATA_W:0]          w_fifo_head;
    logic                       w_fifo_valid;
    logic [1:0]                 w_fifo_count;

    assign w_row_last   = ({1'b0, r_row_cnt} == (r_rows - (ADDR_WIDTH+1)'(1)));
    assign w_final_pass = (r_kt_cnt == (r_k_tiles - KT_W'(1)));
    assign w_cfg_fire   = bus.cfg_valid && r_cfg_ready;
    assign w_cfg_bad    = (bus.cfg_rows == '0) || (bus.cfg_rows > c_MAX_ROWS) ||
                          (bus.cfg_k_tiles == '0);

    // Final-pass beats are only taken when the FIFO can absorb them.
    assign w_inflight = r_s1_valid && r_s1_final;
    assign w_room     = (({1'b0, w_fifo_count} + {2'b00, w_inflight}) < 3'd2);
    assign w_in_ready = (r_state == ACCUM) && (!w_final_pass || w_room);
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = w_fifo_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_cfg   <= 1'b0;
            r_rows      <= '0;
            r_k_tiles   <= '0;
            r_mode      <= RAW;
            r_shift     <= '0;
            r_row_cnt   <= '0;
            r_kt_cnt    <= '0;
        end else begin
            r_done    <= 1'b0;
            r_err_cfg <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cfg_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    if (w_cfg_fire) begin
                        if (w_cfg_bad) begin
                            r_err_cfg <= 1'b1;
                        end else begin
                            r_rows      <= bus.cfg_rows;
                            r_k_tiles   <= bus.cfg_k_tiles;
                            r_mode      <= acc_mode_e'(bus.cfg_mode);
                            r_shift     <= bus.cfg_shift;
                            r_row_cnt   <= '0;
                            r_kt_cnt    <= '0;
                            r_cfg_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_in_fire) begin
                        if (w_row_last) begin
                            r_row_cnt <= '0;
                            if (w_final_pass) r_state  <= DRAIN;
                            else              r_kt_cnt <= r_kt_cnt + KT_W'(1);
                        end else begin
                            r_row_cnt <= r_row_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_out_fire && w_fifo_head[c_DATA_W]) begin
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_final <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_row   <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_in_fire;
            if (w_in_fire) begin
                r_s1_first <= (r_kt_cnt == '0);
                r_s1_final <= w_final_pass;
                r_s1_last  <= w_final_pass && w_row_last;
                r_s1_row   <= r_row_cnt;
                r_s1_data  <= bus.in_data;
            end
        end
    end

    // The write lands on the same edge the next beat enters stage 1, so the
    // asynchronous read already returns it when rows is 1 or 2.
    assign w_rd_row = r_mem[r_s1_row];

    always_ff @(posedge clk) begin
        if (r_s1_valid && !r_s1_final) r_mem[r_s1_row] <= w_sum_row;
    end

    for (genvar gi = 0; gi < N_SIZE; gi++) begin : g_lane
        logic signed [ACC_W-1:0] w_in_lane;
        logic signed [ACC_W-1:0] w_mem_lane;
        logic signed [ACC_W-1:0] w_sum;
        logic signed [ACC_W:0]   w_rnd;
        logic signed [ACC_W:0]   w_ext;
        logic signed [ACC_W:0]   w_shifted;
        logic signed [ACC_W:0]   w_q;

        assign w_in_lane  = r_s1_data[gi*ACC_W +: ACC_W];
        assign w_mem_lane = r_s1_first ? '0 : w_rd_row[gi*ACC_W +: ACC_W];
        assign w_sum      = w_mem_lane + w_in_lane;

        assign w_rnd      = (r_shift == 5'd0) ? '0 : (c_ONE << (r_shift - 5'd1));
        assign w_ext      = {w_sum[ACC_W-1], w_sum} + w_rnd;
        assign w_shifted  = w_ext >>> r_shift;
        assign w_q        = (w_shifted > c_QMAX) ? c_QMAX :
                            (w_shifted < c_QMIN) ? c_QMIN : w_shifted;

        assign w_sum_row[gi*ACC_W +: ACC_W] = w_sum;
        assign w_out_row[gi*ACC_W +: ACC_W] = (r_mode == REQUANT) ? w_q[ACC_W-1:0] : w_sum;
    end

    psum_out_fifo #(
        .WIDTH (c_DATA_W + 1)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_inflight),
        .push_data ({r_s1_last, w_out_row}),
        .pop       (bus.out_ready),
        .pop_data  (w_fifo_head),
        .valid     (w_fifo_valid),
        .count     (w_fifo_count)
    );

    assign bus.cfg_ready = r_cfg_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_fifo_valid;
    assign bus.out_data  = w_fifo_valid ? w_fifo_head[c_DATA_W-1:0] : '0;
    assign bus.out_last  = w_fifo_valid && w_fifo_head[c_DATA_W];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err_cfg   = r_err_cfg;
endmodule
`default_nettype wire

// File: tb/tb_psum_tile_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_tile_accumulator
// Description : Randomised scoreboard bench for psum_tile_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_tile_accumulator;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int MR  = 16;
    localparam int ADW = 4;
    localparam int KW  = 8;
    localparam int DW  = N * AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psum_tile_accumulator_if #(.N_SIZE(N), .ACC_W(AW), .ADDR_WIDTH(ADW), .KT_W(KW)) bus ();

    psum_tile_accumulator #(
        .N_SIZE(N), .ACC_W(AW), .OUT_W(8), .MAX_ROWS(MR), .ADDR_WIDTH(ADW), .KT_W(KW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_done = 0;
    int          n_err_pulse = 0;
    int          last_xfer_cyc = -10;
    int          hold = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] stim [0:3][0:15][0:3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // Reference requantisation from plain integer arithmetic.
    function automatic logic [31:0] requant(input logic [31:0] s, input int sh);
        longint v;
        v = longint'(signed'(s));
        if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v[31:0];
    endfunction

    // Monitor: pops the scoreboard on every output transfer.
    initial begin
        exp_t          e;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_data", bus.out_data, prev_data);
                    check("hold_last", DW'(bus.out_last), DW'(prev_last));
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out: actual=%h required=none", bus.out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", bus.out_data, e.data);
                        check("out_last", DW'(bus.out_last), DW'(e.last));
                    end
                    if (bus.out_last) last_xfer_cyc = cyc;
                end
                if (bus.done) begin
                    n_done++;
                    check("done_timing", DW'(cyc), DW'(last_xfer_cyc + 1));
                end
                if (bus.err_cfg) n_err_pulse++;
            end
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                bus.out_ready = 1'b0;
                hold--;
            end else begin
                bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic send_cfg(input int rows, input int kt, input bit mode, input int shift,
                            output bit ok);
        int w;
        w  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!bus.cfg_ready) begin
            w++;
            if (w > 100) begin
                timeout("cfg_ready_wait");
                ok = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.cfg_valid   = 1'b1;
        bus.cfg_rows    = (ADW+1)'(rows);
        bus.cfg_k_tiles = KW'(kt);
        bus.cfg_mode    = mode;
        bus.cfg_shift   = 5'(shift);
        @(negedge clk);
        bus.cfg_valid   = 1'b0;
    endtask

    task automatic run_job(input int rows, input int kt, input bit mode, input int shift,
                           input int hold_c, input bit gaps, input int rst_after,
                           output int acc_before_block, output int stall_nf);
        exp_t          e;
        logic [31:0]   s;
        logic [DW-1:0] d;
        int            done0;
        int            acc;
        int            w;
        bit            ok;
        done0            = n_done;
        acc_before_block = -1;
        stall_nf         = 0;
        acc              = 0;
        for (int r = 0; r < rows; r++) begin
            for (int l = 0; l < N; l++) begin
                s = 32'd0;
                for (int k = 0; k < kt; k++) s = s + stim[k][r][l];
                e.data[l*AW +: AW] = mode ? requant(s, shift) : s;
            end
            e.last = (r == rows - 1);
            sb.push_back(e);
        end
        send_cfg(rows, kt, mode, shift, ok);
        if (!ok) return;
        hold = hold_c;
        for (int k = 0; k < kt; k++) begin
            for (int r = 0; r < rows; r++) begin
                if (gaps && ($urandom_range(0, 3) == 0)) begin
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                end
                for (int l = 0; l < N; l++) d[l*AW +: AW] = stim[k][r][l];
                bus.in_valid = 1'b1;
                bus.in_data  = d;
                w = 0;
                while (!bus.in_ready) begin
                    if (acc_before_block < 0) acc_before_block = acc;
                    if (k != kt - 1) stall_nf++;
                    w++;
                    if (w > 200) begin
                        bus.in_valid = 1'b0;
                        timeout("in_ready_wait");
                        return;
                    end
                    @(negedge clk);
                end
                @(negedge clk);
                acc++;
                if (acc == rst_after) begin
                    bus.in_valid = 1'b0;
                    rst = 1'b1;
                    sb.delete();
                    repeat (2) @(negedge clk);
                    rst = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
        w = 0;
        while (n_done == done0) begin
            w++;
            if (w > 400) begin
                timeout("done_wait");
                return;
            end
            @(negedge clk);
        end
        check("sb_drained", DW'(sb.size()), DW'(0));
    endtask

    initial begin
        int  abb;
        int  snf;
        int  e0;
        int  d0;
        bit  ok;
        int  rows;
        int  kt;
        bit  mode;
        int  sh;
        bus.cfg_valid   = 1'b0;
        bus.cfg_rows    = '0;
        bus.cfg_k_tiles = '0;
        bus.cfg_mode    = 1'b0;
        bus.cfg_shift   = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cfg_ready", DW'(bus.cfg_ready), DW'(0));
        check("rst_busy",      DW'(bus.busy),      DW'(0));
        check("rst_out_valid", DW'(bus.out_valid), DW'(0));
        check("rst_in_ready",  DW'(bus.in_ready),  DW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_cfg_ready_c0", DW'(bus.cfg_ready), DW'(0));
        @(negedge clk);
        check("post_rst_cfg_ready_c1", DW'(bus.cfg_ready), DW'(1));

        // Three rows, two tiles: 5 + 7 per lane.
        for (int r = 0; r < 3; r++)
            for (int l = 0; l < N; l++) begin
                stim[0][r][l] = 32'd5;
                stim[1][r][l] = 32'd7;
            end
        run_job(3, 2, 1'b0, 0, 0, 1'b0, -1, abb, snf);
        check("busy_after_job", DW'(bus.busy), DW'(0));

        // Single row over four tiles: exercises the back-to-back RAW path.
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < N; l++) stim[k][0][l] = 32'(l + 1);
        run_job(1, 4, 1'b0, 0, 0, 1'b0, -1, abb, snf);
        check("nonfinal_stalls", DW'(snf), DW'(0));

        // Requant rounding and saturation.
        stim[0][0][0] = 32'd40;
        stim[0][0][1] = -32'sd40;
        stim[0][0][2] = 32'd5000;
        stim[0][0][3] = -32'sd5000;
        run_job(1, 1, 1'b1, 4, 0, 1'b0, -1, abb, snf);

        // Output stalled: only two final rows may be buffered.
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < N; l++) stim[0][r][l] = $urandom;
        run_job(4, 1, 1'b0, 0, 10, 1'b0, -1, abb, snf);
        check("accepted_before_block", DW'(abb), DW'(2));

        // Rejected configurations.
        e0 = n_err_pulse;
        send_cfg(0, 1, 1'b0, 0, ok);
        repeat (2) @(negedge clk);
        check("err_rows0", DW'(n_err_pulse), DW'(e0 + 1));
        check("err_rows0_busy", DW'(bus.busy), DW'(0));
        check("err_rows0_cfg_ready", DW'(bus.cfg_ready), DW'(1));
        send_cfg(2, 0, 1'b0, 0, ok);
        repeat (2) @(negedge clk);
        check("err_kt0", DW'(n_err_pulse), DW'(e0 + 2));
        check("err_kt0_busy", DW'(bus.busy), DW'(0));
        send_cfg(MR + 1, 1, 1'b0, 0, ok);
        repeat (2) @(negedge clk);
        check("err_rows_max", DW'(n_err_pulse), DW'(e0 + 3));
        check("err_rows_max_cfg_ready", DW'(bus.cfg_ready), DW'(1));

        // Reset in the middle of pass 1, then a fresh single-tile job.
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 2; r++)
                for (int l = 0; l < N; l++) stim[k][r][l] = $urandom;
        d0 = n_done;
        run_job(2, 3, 1'b0, 0, 0, 1'b0, 3, abb, snf);
        repeat (3) @(negedge clk);
        check("no_done_on_rst", DW'(n_done), DW'(d0));
        check("rst_mid_out_valid", DW'(bus.out_valid), DW'(0));
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < N; l++) stim[0][r][l] = $urandom;
        run_job(2, 1, 1'b0, 0, 0, 1'b0, -1, abb, snf);

        // Randomised jobs with random back-pressure and input gaps.
        rand_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            rows = (j == 0) ? MR : int'($urandom_range(1, MR));
            kt   = int'($urandom_range(1, 4));
            mode = 1'($urandom_range(0, 1));
            sh   = int'($urandom_range(0, 12));
            for (int k = 0; k < kt; k++)
                for (int r = 0; r < rows; r++)
                    for (int l = 0; l < N; l++)
                        stim[k][r][l] = mode ? (32'($urandom_range(0, 8000)) - 32'd4000)
                                             : 32'($urandom);
            run_job(rows, kt, mode, sh, 0, 1'b1, -1, abb, snf);
            check("rand_nonfinal_stalls", DW'(snf), DW'(0));
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
